// File: rtl/blinky_pkg.sv
// Shared types and constants for the blinker family (LED blinker and its receive-side monitor).
package blinky_pkg;

    localparam int unsigned CounterWidth = 8;
    localparam int unsigned StatsWidth   = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSeek,
        StAcq,
        StLocked,
        StLost
    } blink_mon_state_e;

endpackage

// File: rtl/blink_sync.sv
// Two-flop synchroniser for an asynchronous input, followed by a toggle (any-edge) detector.
module blink_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign q_o    = sync2_q;
    assign edge_o = sync2_q ^ prev_q;

endmodule

// File: rtl/blink_monitor.sv
// Measures toggle-to-toggle intervals of an asynchronous blink input and tracks lock/activity.
// Define BLINK_MON_STATS_EN to enable the saturating toggle counter on edge_cnt_o.
module blink_monitor
    import blinky_pkg::*;
#(
    parameter int unsigned              CounterWidth = blinky_pkg::CounterWidth,
    parameter int unsigned              Tol          = 2,
    parameter int unsigned              LockCount    = 3,
    parameter logic [CounterWidth-1:0]  Timeout      = {CounterWidth{1'b1}}
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    blink_i,
    output logic [CounterWidth-1:0] half_period_o,
    output logic                    valid_o,
    output logic                    locked_o,
    output logic                    timeout_o,
    output logic [StatsWidth-1:0]   edge_cnt_o
);

    localparam int unsigned MatchW = (LockCount < 2) ? 1 : $clog2(LockCount + 1);
    localparam logic [MatchW-1:0]     LockTarget = MatchW'(LockCount);
    localparam logic [CounterWidth:0] TolW       = (CounterWidth + 1)'(Tol);
    localparam logic [CounterWidth-1:0] CntMax   = {CounterWidth{1'b1}};

    logic edge_w;
    logic sync_w;
    logic unused_sync;

    blink_sync u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (blink_i),
        .q_o    (sync_w),
        .edge_o (edge_w)
    );

    assign unused_sync = sync_w;

    blink_mon_state_e        state_q, state_d;
    logic [CounterWidth-1:0] cnt_q, cnt_d;
    logic [CounterWidth-1:0] ref_q, ref_d;
    logic                    ref_vld_q, ref_vld_d;
    logic [MatchW-1:0]       match_q, match_d;
    logic [CounterWidth-1:0] hp_q, hp_d;
    logic                    valid_q, valid_d;
    logic                    locked_q, locked_d;
    logic                    timeout_q, timeout_d;

    logic [CounterWidth:0]   diff;
    logic                    in_tol;
    logic [MatchW-1:0]       match_inc;

    // Extra bit keeps the absolute difference from wrapping.
    always_comb begin
        if (cnt_q >= ref_q) begin
            diff = {1'b0, cnt_q} - {1'b0, ref_q};
        end else begin
            diff = {1'b0, ref_q} - {1'b0, cnt_q};
        end
    end

    assign in_tol    = (diff <= TolW);
    assign match_inc = match_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        match_d   = match_q;
        hp_d      = hp_q;
        valid_d   = 1'b0;

        if (edge_w) begin
            cnt_d = CounterWidth'(1);
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                ref_d     = '0;
                ref_vld_d = 1'b0;
                match_d   = '0;
                state_d   = StSeek;
            end
            StSeek: begin
                if (edge_w) begin
                    state_d   = StAcq;
                    ref_vld_d = 1'b0;
                    match_d   = '0;
                end
            end
            StAcq, StLocked: begin
                if (edge_w) begin
                    hp_d    = cnt_q;
                    valid_d = 1'b1;
                    if (!ref_vld_q) begin
                        ref_d     = cnt_q;
                        ref_vld_d = 1'b1;
                        match_d   = '0;
                    end else if (in_tol) begin
                        // Once locked the match count is no longer needed; hold it.
                        if (state_q == StAcq) begin
                            match_d = match_inc;
                            if (match_inc == LockTarget) begin
                                state_d = StLocked;
                            end
                        end
                    end else begin
                        ref_d   = cnt_q;
                        match_d = '0;
                        state_d = StAcq;
                    end
                end else if (cnt_q == Timeout) begin
                    state_d = StLost;
                end
            end
            StLost: begin
                if (edge_w) begin
                    state_d   = StAcq;
                    ref_vld_d = 1'b0;
                    match_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (!en_i) begin
            state_d = StIdle;
            hp_d    = hp_q;
            valid_d = 1'b0;
        end
    end

    assign locked_d  = (state_d == StLocked);
    assign timeout_d = (state_d == StLost);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            match_q   <= '0;
            hp_q      <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            match_q   <= match_d;
            hp_q      <= hp_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign half_period_o = hp_q;
    assign valid_o       = valid_q;
    assign locked_o      = locked_q;
    assign timeout_o     = timeout_q;

`ifdef BLINK_MON_STATS_EN
    logic [StatsWidth-1:0] edge_cnt_q;

    // Counts while enabled regardless of state; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edge_cnt_q <= '0;
        end else if (edge_w && en_i && (edge_cnt_q != {StatsWidth{1'b1}})) begin
            edge_cnt_q <= edge_cnt_q + 1'b1;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
`else
    assign edge_cnt_o = '0;
`endif

endmodule
